// File: rtl/timer_pkg.sv
// Shared types and constants for the 00..59 seconds counter.
package timer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // Active-high segment patterns, bit0=a .. bit6=g, entry N is digit N.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes blank the display.
// Zero latency, no flow control.
module bcd_to_7seg
  import timer_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  logic [6:0] w_seg_ah;

  always_comb begin
    w_seg_ah = 7'h00;
    if (i_bcd <= ONES_MAX) w_seg_ah = SEG_TABLE[i_bcd];
  end

  assign o_seg = SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
endmodule

// File: rtl/seconds_counter_60.sv
// Start/stop/clear seconds counter 00..59 driven by an asynchronous 1 Hz tick.
// A Tickin rise updates the count SYNC_STAGES+1 edges after it is first sampled.
module seconds_counter_60
  import timer_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clockin,
  input  logic       Resetn,
  input  logic       Tickin,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  output logic [3:0] Ones,
  output logic [3:0] Tens,
  output logic [6:0] Seg_ones,
  output logic [6:0] Seg_tens,
  output logic       Running,
  output logic       Done
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_tick;
  logic                   w_synced;
  state_t                 r_state;
  logic [3:0]             r_ones;
  logic [3:0]             r_tens;
  logic                   r_running;
  logic                   r_done;
  logic                   w_at_max;
  logic                   w_bad;
  logic                   w_start;
  logic [3:0]             w_ones_inc;
  logic [3:0]             w_tens_inc;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // The tick pulse is registered so the counter sees a clean one-cycle strobe.
  always_ff @(posedge Clockin or negedge Resetn) begin
    if (!Resetn) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Tickin};
      r_hist <= w_synced;
      r_tick <= w_synced & ~r_hist;
    end
  end

  assign w_at_max = (r_ones == ONES_MAX) && (r_tens == TENS_MAX);
  assign w_bad    = (r_ones > ONES_MAX) || (r_tens > TENS_MAX);
  assign w_start  = Start && !Stop;

  always_comb begin
    w_ones_inc = r_ones + 4'd1;
    w_tens_inc = r_tens;
    if (w_bad) begin
      w_ones_inc = 4'd0;
      w_tens_inc = 4'd0;
    end else if (r_ones == ONES_MAX) begin
      w_ones_inc = 4'd0;
      w_tens_inc = r_tens + 4'd1;
    end
  end

  always_ff @(posedge Clockin or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= ST_IDLE;
      r_ones    <= 4'd0;
      r_tens    <= 4'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else if (Clear) begin
      r_state   <= ST_IDLE;
      r_ones    <= 4'd0;
      r_tens    <= 4'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_tick && w_at_max) begin
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            if (r_tick) begin
              r_ones <= w_ones_inc;
              r_tens <= w_tens_inc;
            end
            if (Stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (w_start) begin
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        default: begin
          if (w_start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Ones    = r_ones;
  assign Tens    = r_tens;
  assign Running = r_running;
  assign Done    = r_done;

  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ones (
    .i_bcd (r_ones),
    .o_seg (Seg_ones)
  );

  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_tens (
    .i_bcd (r_tens),
    .o_seg (Seg_tens)
  );
endmodule

// File: tb/tb_seconds_counter_60.sv
// Bench for seconds_counter_60: per-cycle comparison against a seconds/mode model plus directed checks.
module tb_seconds_counter_60;
  logic       Clockin;
  logic       Resetn;
  logic       Tickin;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic [3:0] Ones;
  logic [3:0] Tens;
  logic [6:0] Seg_ones;
  logic [6:0] Seg_tens;
  logic       Running;
  logic       Done;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int cnt;
    int mode;
  } model_t;

  model_t   m      = '{cnt: 0, mode: M_IDLE};
  bit [3:0] m_hist = 4'b0000;

  logic [6:0] seg_ah [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seconds_counter_60 dut (
    .Clockin  (Clockin),
    .Resetn   (Resetn),
    .Tickin   (Tickin),
    .Start    (Start),
    .Stop     (Stop),
    .Clear    (Clear),
    .Ones     (Ones),
    .Tens     (Tens),
    .Seg_ones (Seg_ones),
    .Seg_tens (Seg_tens),
    .Running  (Running),
    .Done     (Done)
  );

  initial begin
    Clockin = 1'b0;
    forever #5 Clockin = ~Clockin;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: a tick acts three edges after Tickin was first seen high following a low sample.
  function automatic model_t step(model_t cur, bit tk, bit st, bit sp, bit cl);
    model_t n = cur;
    if (cl) begin
      n.cnt  = 0;
      n.mode = M_IDLE;
    end else if (cur.mode == M_RUN) begin
      if (tk) begin
        n.cnt = (cur.cnt + 1) % 60;
        if (n.cnt == 0) n.mode = M_DONE;
        else if (sp) n.mode = M_PAUSE;
      end else if (sp) begin
        n.mode = M_PAUSE;
      end
    end else if (st && !sp) begin
      n.mode = M_RUN;
      if (cur.mode == M_DONE) n.cnt = 0;
    end
    return n;
  endfunction

  always @(posedge Clockin or negedge Resetn) begin
    if (!Resetn) begin
      m      <= '{cnt: 0, mode: M_IDLE};
      m_hist <= 4'b0000;
    end else begin
      m      <= step(m, m_hist[2] & ~m_hist[3], Start, Stop, Clear);
      m_hist <= {m_hist[2:0], Tickin};
    end
  end

  always @(negedge Clockin) begin
    logic [23:0] act;
    logic [23:0] exp;
    act = {Ones, Tens, Seg_ones, Seg_tens, Running, Done};
    exp = {4'(m.cnt % 10), 4'(m.cnt / 10), ~seg_ah[m.cnt % 10], ~seg_ah[m.cnt / 10],
           m.mode == M_RUN, m.mode == M_DONE};
    chk("cycle_model", 32'(act), 32'(exp));
  end

  task automatic cyc();
    @(posedge Clockin);
    #2;
  endtask

  task automatic do_tick();
    Tickin = 1'b1;
    repeat (4) cyc();
    Tickin = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic chk_count(input string nm, input int t, input int o);
    chk({nm, "_tens"}, 32'(Tens), 32'(t));
    chk({nm, "_ones"}, 32'(Ones), 32'(o));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk_count(nm, 0, 0);
    chk({nm, "_seg_ones"}, 32'(Seg_ones), 32'h40);
    chk({nm, "_seg_tens"}, 32'(Seg_tens), 32'h40);
    chk({nm, "_running"}, 32'(Running), 32'd0);
    chk({nm, "_done"}, 32'(Done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, limit %0d ns", 200000);
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b1;
    Tickin = 1'b1;
    Start  = 1'b0;
    Stop   = 1'b0;
    Clear  = 1'b0;
    #1 Resetn = 1'b0;
    #11;
    chk_reset_vals("in_reset");
    cyc();
    Resetn = 1'b1;
    repeat (10) cyc();
    chk_reset_vals("release_tick_high");
    Tickin = 1'b0;
    repeat (2) cyc();

    Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("start_running", 32'(Running), 32'd1);
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      chk_count("wrap_seq", (i % 60) / 10, i % 10);
    end
    chk("after60_done", 32'(Done), 32'd1);
    chk("after60_running", 32'(Running), 32'd0);
    repeat (2) do_tick();
    chk_count("done_hold", 0, 0);
    chk("done_hold_done", 32'(Done), 32'd1);

    Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("restart_done", 32'(Done), 32'd0);
    repeat (9) do_tick();
    chk_count("at09", 0, 9);
    Tickin = 1'b1;
    repeat (3) cyc();
    chk_count("carry_k2", 0, 9);
    cyc();
    chk_count("carry_k3", 1, 0);
    Tickin = 1'b0;
    repeat (4) cyc();

    repeat (13) do_tick();
    chk_count("at23", 2, 3);
    Tickin = 1'b1;
    repeat (3) cyc();
    Stop = 1'b1;
    cyc();
    Stop = 1'b0;
    Tickin = 1'b0;
    chk_count("stop_tick", 2, 4);
    chk("stop_running", 32'(Running), 32'd0);
    repeat (4) cyc();
    repeat (5) do_tick();
    chk_count("pause_hold", 2, 4);
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    do_tick();
    chk_count("resume", 2, 5);

    repeat (12) do_tick();
    chk_count("at37", 3, 7);
    Tickin = 1'b1;
    repeat (3) cyc();
    Clear = 1'b1;
    Start = 1'b1;
    cyc();
    Clear = 1'b0;
    Start = 1'b0;
    Tickin = 1'b0;
    chk_count("clear_all", 0, 0);
    chk("clear_running", 32'(Running), 32'd0);
    repeat (6) cyc();
    chk_count("clear_idle_hold", 0, 0);

    Start = 1'b1;
    cyc();
    Start = 1'b0;
    repeat (45) do_tick();
    chk_count("at45", 4, 5);
    cyc();
    #1 Resetn = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    cyc();
    Resetn = 1'b1;
    repeat (5) cyc();
    chk_reset_vals("post_reset_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seconds_counter_60.md
SECONDS_COUNTER_60 -- requirements
Module: seconds_counter_60

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1, meaning: 1 drives segment outputs active-low (common-anode), 0 drives them active-high.
REQ-002 Parameter SYNC_STAGES, default 2, meaning: number of synchroniser flops on Tickin (legal values 2..3).
REQ-003 Clockin  input  1  system clock; all state changes on its rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Tickin  input  1  1 Hz square wave from the divide-by-10 chain; treated as asynchronous data, never used as a clock.
REQ-006 Start  input  1  level, sampled each cycle; begin or resume counting.
REQ-007 Stop  input  1  level, sampled each cycle; pause counting.
REQ-008 Clear  input  1  level, sampled each cycle; return to 00 and idle.
REQ-009 Ones  output  4  BCD seconds units, 0..9.
REQ-010 Tens  output  4  BCD seconds tens, 0..5.
REQ-011 Seg_ones  output  7  seven-segment pattern for Ones; bit0=a ... bit6=g.
REQ-012 Seg_tens  output  7  seven-segment pattern for Tens; same bit order.
REQ-013 Running  output  1  high while the FSM is in RUN.
REQ-014 Done  output  1  high while the FSM is in DONE.

Function
REQ-015 Tickin passes through SYNC_STAGES flops, then one history flop; tick pulse = synced high AND history low, one Clockin cycle wide.
REQ-016 With SYNC_STAGES=2, a Tickin rise first sampled at edge k updates Ones/Tens at edge k+3.
REQ-017 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-018 Control priority each cycle: Clear > Stop > Start.
REQ-019 IDLE: Start -> RUN. Ticks are ignored and the count holds at 00.
REQ-020 RUN: on a tick, Ones increments; 9 -> 0 carries into Tens.
REQ-021 RUN: a tick at 59 sets the count to 00 and moves to DONE in the same edge.
REQ-022 RUN: Stop -> PAUSE; a tick in the same cycle is still counted.
REQ-023 PAUSE: count holds and ticks are ignored; Start -> RUN.
REQ-024 DONE: count holds at 00 and ticks are ignored; Start -> RUN (Done drops, counting resumes from 00).
REQ-025 Any state: Clear -> IDLE with count 00 on the next edge; a tick in the same cycle is discarded.
REQ-026 The edge detector runs in every state, so no stale tick is counted after a state change.
REQ-027 Ones never exceeds 9 and Tens never exceeds 5; any out-of-range value forces 00 on the next tick.
REQ-028 All outputs are registered.
REQ-029 Seg_* reflect the current Ones/Tens with zero added cycles (decoded from the digit registers).
REQ-030 Seg_* encode 0-9 in the standard pattern, inverted when SEG_ACTIVE_LOW=1.

Reset
REQ-031 Resetn low asynchronously forces: FSM=IDLE, Ones=0, Tens=0, Running=0, Done=0, all synchroniser and history flops=0.
REQ-032 During reset, Seg_ones and Seg_tens show "0": 7'b1000000 when SEG_ACTIVE_LOW=1, 7'b0111111 otherwise.
REQ-033 Reset release is synchronous to Clockin (deasserted by the upstream reset synchroniser).
REQ-034 A Tickin that is already high at reset release yields one edge pulse, which is discarded because the FSM is in IDLE.

Structure
REQ-035 Package timer_pkg holds: the state enum, ONES_MAX=9, TENS_MAX=5, and the 10-entry seven-segment table (active-high).
REQ-036 Sub-module bcd_to_7seg (4-bit in, 7-bit out, active-low parameter) is instantiated twice.
REQ-037 The synchroniser, edge detector, FSM and BCD counter reside in seconds_counter_60.

Verification
REQ-038 Reset with Tickin=1, then release and hold 10 cycles -> IDLE, 00, Seg_ones=Seg_tens=7'b1000000, no count.
REQ-039 Start, then 60 Tickin rises -> count 01..59 then 00; Done=1 and Running=0 after the 60th; further ticks keep 00.
REQ-040 Count at 09, then one tick -> Ones=0 and Tens=1 exactly 3 edges after the sampled rise.
REQ-041 RUN at 23, with Stop and tick in the same cycle -> count 24 and PAUSE; 5 ticks -> still 24; Start plus 1 tick -> 25.
REQ-042 RUN at 37, with Clear, Start and tick all in one cycle -> IDLE at 00 with Running=0.
REQ-043 Resetn pulsed low mid-RUN at 45 -> outputs take reset values immediately, without waiting for a clock edge.
